// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: retires one instruction per handshake into the
// register-file write port, extending load data and flagging errors.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   wb_valid / wb_ready       accept handshake (ready only in IDLE)
//   ir, aluans, pc_plus4      retiring instruction payload
//   RegDst, MemToReg,
//   RegWrite, Link            decoded control bits
//   mem_rdata, mem_rvalid     load response (single-cycle strobe)
//   rf_we, rf_waddr, rf_wdata registered register-file write port
//   retire_cnt                committed instruction count (wraps)
//   err_align, err_timeout    sticky error flags
module reg_writeback_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [31:0]      ir,
  input  logic [31:0]      aluans,
  input  logic [31:0]      pc_plus4,
  input  logic             RegDst,
  input  logic             MemToReg,
  input  logic             RegWrite,
  input  logic             Link,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err_align,
  output logic             err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    COMMIT
  } state_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  // Last counter value before the wait is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t           state_q;
  logic [5:0]       op_q;
  logic [1:0]       addr_lo_q;
  logic [4:0]       dest_q;
  logic             we_pend_q;
  logic [15:0]      wait_q;
  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;
  logic [CNT_W-1:0] retire_q;
  logic             err_align_q;
  logic             err_timeout_q;

  logic [4:0]  dest_c;
  logic        is_load_c;
  logic        misalign_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] ext_c;

  // ir bits not involved in writeback (rs, shamt/funct/imm).
  logic unused_ir;
  assign unused_ir = ^{ir[25:21], ir[10:0]};

  always_comb begin
    dest_c = RegDst ? ir[15:11] : ir[20:16];
    if (Link) dest_c = 5'd31;
  end

  assign is_load_c = MemToReg && !Link;

  always_comb begin
    misalign_c = 1'b0;
    case (ir[31:26])
      OP_LH, OP_LHU: misalign_c = aluans[0];
      OP_LW:         misalign_c = |aluans[1:0];
      default:       misalign_c = 1'b0;
    endcase
  end

  // Little-endian lane select from the latched low address bits.
  always_comb begin
    byte_c = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    half_c = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_c  = mem_rdata;
    case (op_q)
      OP_LB:   ext_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  ext_c = {24'h0, byte_c};
      OP_LH:   ext_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  ext_c = {16'h0, half_c};
      default: ext_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= 6'h0;
      addr_lo_q     <= 2'b00;
      dest_q        <= 5'd0;
      we_pend_q     <= 1'b0;
      wait_q        <= 16'd0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= 5'd0;
      rf_wdata_q    <= 32'hcccccccc;
      retire_q      <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse.
      rf_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wb_valid) begin
            op_q      <= ir[31:26];
            addr_lo_q <= aluans[1:0];
            dest_q    <= dest_c;
            we_pend_q <= RegWrite && (dest_c != 5'd0);
            if (is_load_c && misalign_c) begin
              // Dropped at accept: stay ready, no memory wait.
              err_align_q <= 1'b1;
            end else if (is_load_c) begin
              wait_q  <= 16'd0;
              state_q <= WAIT_MEM;
            end else begin
              rf_we_q    <= RegWrite && (dest_c != 5'd0);
              rf_waddr_q <= dest_c;
              rf_wdata_q <= Link ? pc_plus4 : aluans;
              retire_q   <= retire_q + CNT_W'(1);
              state_q    <= COMMIT;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            rf_we_q    <= we_pend_q;
            rf_waddr_q <= dest_q;
            rf_wdata_q <= ext_c;
            retire_q   <= retire_q + CNT_W'(1);
            wait_q     <= 16'd0;
            state_q    <= COMMIT;
          end else if (wait_q == WAIT_LAST) begin
            err_timeout_q <= 1'b1;
            wait_q        <= 16'd0;
            state_q       <= IDLE;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wb_ready    = (state_q == IDLE);
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign retire_cnt  = retire_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed scenario tests for reg_writeback_unit.
// Inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_reg_writeback_unit;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] ir;
  logic [31:0] aluans;
  logic [31:0] pc_plus4;
  logic        RegDst;
  logic        MemToReg;
  logic        RegWrite;
  logic        Link;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] retire_cnt;
  logic        err_align;
  logic        err_timeout;

  int checks;
  int passed;

  reg_writeback_unit #(
    .TIMEOUT(4),
    .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .ir         (ir),
    .aluans     (aluans),
    .pc_plus4   (pc_plus4),
    .RegDst     (RegDst),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .Link       (Link),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .retire_cnt (retire_cnt),
    .err_align  (err_align),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i_ir, input logic [31:0] i_alu,
                       input logic [31:0] i_pc, input logic i_rd,
                       input logic i_m2r, input logic i_rw,
                       input logic i_lnk);
    ir       = i_ir;
    aluans   = i_alu;
    pc_plus4 = i_pc;
    RegDst   = i_rd;
    MemToReg = i_m2r;
    RegWrite = i_rw;
    Link     = i_lnk;
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (rf_we !== 1'b0) $display("FAIL rst_we got %b exp 0", rf_we);
    else passed++;
    checks++;
    if (rf_waddr !== 5'd0) $display("FAIL rst_waddr got %0d exp 0", rf_waddr);
    else passed++;
    checks++;
    if (rf_wdata !== 32'hcccccccc)
      $display("FAIL rst_wdata got %h exp cccccccc", rf_wdata);
    else passed++;
    checks++;
    if (retire_cnt !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", retire_cnt);
    else passed++;
    checks++;
    if ({err_align, err_timeout} !== 2'b00)
      $display("FAIL rst_err got %b exp 00", {err_align, err_timeout});
    else passed++;
    checks++;
    if (wb_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", wb_ready);
    else passed++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_addu();
    // addu $5, $1, $2
    offer(32'h00222821, 32'h12345678, 32'h00400004, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rf_we !== 1'b1) $display("FAIL addu_we got %b exp 1", rf_we);
    else passed++;
    checks++;
    if (rf_waddr !== 5'd5) $display("FAIL addu_waddr got %0d exp 5", rf_waddr);
    else passed++;
    checks++;
    if (rf_wdata !== 32'h12345678)
      $display("FAIL addu_wdata got %h exp 12345678", rf_wdata);
    else passed++;
    checks++;
    if (retire_cnt !== 16'd1) $display("FAIL addu_cnt got %0d exp 1", retire_cnt);
    else passed++;
    checks++;
    if (wb_ready !== 1'b0) $display("FAIL addu_busy got %b exp 0", wb_ready);
    else passed++;
    step();
    checks++;
    if ({rf_we, wb_ready} !== 2'b01)
      $display("FAIL addu_after got %b exp 01", {rf_we, wb_ready});
    else passed++;
    checks++;
    if (rf_wdata !== 32'h12345678)
      $display("FAIL addu_hold got %h exp 12345678", rf_wdata);
    else passed++;
  endtask

  task automatic test_loads();
    logic [31:0] t_ir   [5];
    logic [31:0] t_alu  [5];
    logic [31:0] t_rd   [5];
    logic [4:0]  t_addr [5];
    logic [31:0] t_exp  [5];
    // lb, lbu, lhu, lh, lw
    t_ir[0] = 32'h80070000; t_alu[0] = 32'h00001002;
    t_rd[0] = 32'h00A50000; t_addr[0] = 5'd7; t_exp[0] = 32'hFFFFFFA5;
    t_ir[1] = 32'h90070000; t_alu[1] = 32'h00001002;
    t_rd[1] = 32'h00A50000; t_addr[1] = 5'd7; t_exp[1] = 32'h000000A5;
    t_ir[2] = 32'h94090000; t_alu[2] = 32'h00001002;
    t_rd[2] = 32'h80010000; t_addr[2] = 5'd9; t_exp[2] = 32'h00008001;
    t_ir[3] = 32'h84030000; t_alu[3] = 32'h00001002;
    t_rd[3] = 32'h80010000; t_addr[3] = 5'd3; t_exp[3] = 32'hFFFF8001;
    t_ir[4] = 32'h8C040000; t_alu[4] = 32'h00001000;
    t_rd[4] = 32'hDEADBEEF; t_addr[4] = 5'd4; t_exp[4] = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      offer(t_ir[k], t_alu[k], 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int w = 0; w < 2; w++) begin
        checks++;
        if ({rf_we, wb_ready} !== 2'b00)
          $display("FAIL ld%0d_wait got %b exp 00", k, {rf_we, wb_ready});
        else passed++;
        step();
      end
      mem_rdata  = t_rd[k];
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      checks++;
      if (rf_we !== 1'b1) $display("FAIL ld%0d_we got %b exp 1", k, rf_we);
      else passed++;
      checks++;
      if (rf_waddr !== t_addr[k])
        $display("FAIL ld%0d_waddr got %0d exp %0d", k, rf_waddr, t_addr[k]);
      else passed++;
      checks++;
      if (rf_wdata !== t_exp[k])
        $display("FAIL ld%0d_wdata got %h exp %h", k, rf_wdata, t_exp[k]);
      else passed++;
      step();
    end
    checks++;
    if (retire_cnt !== 16'd6) $display("FAIL ld_cnt got %0d exp 6", retire_cnt);
    else passed++;
  endtask

  task automatic test_link_and_zero();
    // jal: dest forced to 31, data is the link value
    offer(32'h0C000004, 32'h00000055, 32'h00400010, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd31})
      $display("FAIL jal_we_addr got %b/%0d exp 1/31", rf_we, rf_waddr);
    else passed++;
    checks++;
    if (rf_wdata !== 32'h00400010)
      $display("FAIL jal_wdata got %h exp 00400010", rf_wdata);
    else passed++;
    checks++;
    if (retire_cnt !== 16'd7) $display("FAIL jal_cnt got %0d exp 7", retire_cnt);
    else passed++;
    step();
    // addiu $0, $1, 5: write suppressed, still retires
    offer(32'h24200005, 32'h00000099, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rf_we !== 1'b0) $display("FAIL zero_we got %b exp 0", rf_we);
    else passed++;
    checks++;
    if (retire_cnt !== 16'd8) $display("FAIL zero_cnt got %0d exp 8", retire_cnt);
    else passed++;
    step();
  endtask

  task automatic test_misalign();
    // lh $3, with address low bit set
    offer(32'h84030000, 32'h00001001, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (err_align !== 1'b1) $display("FAIL mis_err got %b exp 1", err_align);
    else passed++;
    checks++;
    if ({rf_we, wb_ready} !== 2'b01)
      $display("FAIL mis_state got %b exp 01", {rf_we, wb_ready});
    else passed++;
    checks++;
    if (retire_cnt !== 16'd8) $display("FAIL mis_cnt got %0d exp 8", retire_cnt);
    else passed++;
    // addu $6 right after
    offer(32'h00223021, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd6})
      $display("FAIL mis_next got %b/%0d exp 1/6", rf_we, rf_waddr);
    else passed++;
    checks++;
    if (rf_wdata !== 32'hCAFEF00D)
      $display("FAIL mis_next_data got %h exp cafef00d", rf_wdata);
    else passed++;
    step();
  endtask

  task automatic test_timeout();
    offer(32'h8C040000, 32'h00001000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 4; w++) begin
      checks++;
      if ({err_timeout, wb_ready, rf_we} !== 3'b000)
        $display("FAIL to_wait%0d got %b exp 000", w,
                 {err_timeout, wb_ready, rf_we});
      else passed++;
      step();
    end
    checks++;
    if ({err_timeout, wb_ready, rf_we} !== 3'b110)
      $display("FAIL to_abort got %b exp 110", {err_timeout, wb_ready, rf_we});
    else passed++;
    checks++;
    if (retire_cnt !== 16'd9) $display("FAIL to_cnt got %0d exp 9", retire_cnt);
    else passed++;
    mem_rdata  = 32'h11111111;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    checks++;
    if ({rf_we, wb_ready} !== 2'b01)
      $display("FAIL to_late got %b exp 01", {rf_we, wb_ready});
    else passed++;
    checks++;
    if (retire_cnt !== 16'd9) $display("FAIL to_late_cnt got %0d exp 9", retire_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    offer(32'h8C040000, 32'h00001000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (rf_wdata !== 32'hcccccccc)
      $display("FAIL rmid_wdata got %h exp cccccccc", rf_wdata);
    else passed++;
    checks++;
    if ({rf_we, wb_ready, err_align, err_timeout} !== 4'b0100)
      $display("FAIL rmid_flags got %b exp 0100",
               {rf_we, wb_ready, err_align, err_timeout});
    else passed++;
    checks++;
    if ({retire_cnt, rf_waddr} !== {16'd0, 5'd0})
      $display("FAIL rmid_cnt got %0d/%0d exp 0/0", retire_cnt, rf_waddr);
    else passed++;
    step();
    rst = 1'b0;
    mem_rdata  = 32'h22222222;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    checks++;
    if ({rf_we, wb_ready} !== 2'b01)
      $display("FAIL rmid_nowrite got %b exp 01", {rf_we, wb_ready});
    else passed++;
    step();
    offer(32'h00222821, 32'h0000BEEF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({rf_we, rf_waddr, retire_cnt} !== {1'b1, 5'd5, 16'd1})
      $display("FAIL rmid_resume got %b/%0d/%0d exp 1/5/1",
               rf_we, rf_waddr, retire_cnt);
    else passed++;
    step();
  endtask

  initial begin
    checks     = 0;
    passed     = 0;
    rst        = 1'b1;
    wb_valid   = 1'b0;
    ir         = '0;
    aluans     = '0;
    pc_plus4   = '0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    Link       = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    test_reset();
    test_addu();
    test_loads();
    test_link_and_zero();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
